// File: rtl/multicore_pkg.sv
// Shared core types: decoder load/store opcodes, LSU FSM state and the
// alignment-fault helper used by the load/store unit.
package multicore_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [2:0] {
        LDOP_LB  = 3'd0,
        LDOP_LH  = 3'd1,
        LDOP_LW  = 3'd2,
        LDOP_LBU = 3'd3,
        LDOP_LHU = 3'd4
    } t_ldop;

    typedef enum logic [1:0] {
        SOP_SB = 2'd0,
        SOP_SH = 2'd1,
        SOP_SW = 2'd2
    } t_sop;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_REQ   = 3'd1,
        LSU_WAIT  = 3'd2,
        LSU_DRAIN = 3'd3,
        LSU_RESP  = 3'd4
    } t_lsu_state;

    // Halfwords need an even address, words a 4-byte aligned address.
    function automatic logic lsu_misaligned(input logic memwrite, input t_ldop ldop,
                                            input t_sop sop, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (memwrite) begin
            case (sop)
                SOP_SH:  mis = off[0];
                SOP_SW:  mis = |off;
                default: mis = 1'b0;
            endcase
        end else begin
            case (ldop)
                LDOP_LH, LDOP_LHU: mis = off[0];
                LDOP_LW:           mis = |off;
                default:           mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for the load/store unit (purely combinational).
// Ports:
//   i_sop, i_st_off, i_wdata -> o_be, o_wdata : store lane replication and byte enables
//   i_ldop, i_ld_off, i_rdata -> o_rdata      : load lane extraction and sign/zero extension
module lsu_align
    import multicore_pkg::*;
(
    input  t_sop              i_sop,
    input  logic [1:0]        i_st_off,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [BE_W-1:0]   o_be,
    output logic [XLEN-1:0]   o_wdata,
    input  t_ldop             i_ldop,
    input  logic [1:0]        i_ld_off,
    input  logic [XLEN-1:0]   i_rdata,
    output logic [XLEN-1:0]   o_rdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate the datum across every lane so memory picks it up via be.
    always_comb begin
        o_be    = {BE_W{1'b1}};
        o_wdata = i_wdata;
        case (i_sop)
            SOP_SB: begin
                o_be    = BE_W'(4'b0001 << i_st_off);
                o_wdata = {4{i_wdata[7:0]}};
            end
            SOP_SH: begin
                o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = {BE_W{1'b1}};
                o_wdata = i_wdata;
            end
        endcase
    end

    // Load: pick the addressed lane, then extend.
    always_comb begin
        ld_byte = 8'(i_rdata >> {i_ld_off, 3'b000});
        ld_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ldop)
            LDOP_LB:  o_rdata = {{24{ld_byte[7]}}, ld_byte};
            LDOP_LBU: o_rdata = {24'd0, ld_byte};
            LDOP_LH:  o_rdata = {{16{ld_half[15]}}, ld_half};
            LDOP_LHU: o_rdata = {16'd0, ld_half};
            default:  o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/gnt/rvalid handshake to data memory,
// store lane formatting, load extension, stall generation, timeout and flush.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_valid, i_flush, i_memaccess,
//   i_memwrite, i_ldop, i_sop,
//   i_addr, i_wdata                   mem-stage instruction controls and operands
//   o_stall, o_done, o_rdata,
//   o_misaligned, o_bus_err           pipeline-side status / result
//   o_mem_*, i_mem_*                  data memory handshake
module load_store_unit
    import multicore_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic              i_memaccess,
    input  logic              i_memwrite,
    input  t_ldop             i_ldop,
    input  t_sop              i_sop,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misaligned,
    output logic              o_bus_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [BE_W-1:0]   o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    t_lsu_state         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               store_q, store_d;
    t_ldop              ldop_q, ldop_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               mis_q, mis_d;
    logic               err_q, err_d;

    logic               start;
    logic               timeout;
    logic [BE_W-1:0]    st_be;
    logic [XLEN-1:0]    st_wdata;
    logic [XLEN-1:0]    ld_rdata;

    // Store formatting uses the incoming operands; load extraction uses the latched op.
    lsu_align u_align (
        .i_sop    (i_sop),
        .i_st_off (i_addr[1:0]),
        .i_wdata  (i_wdata),
        .o_be     (st_be),
        .o_wdata  (st_wdata),
        .i_ldop   (ldop_q),
        .i_ld_off (addr_q[1:0]),
        .i_rdata  (i_mem_rdata),
        .o_rdata  (ld_rdata)
    );

    assign start   = i_valid & i_memaccess & (state_q == LSU_IDLE);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State and payload registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            ldop_q  <= LDOP_LB;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            ldop_q  <= ldop_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; flush outranks timeout, and gnt with flush still counts as accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        ldop_d  = ldop_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        err_d   = err_q;
        case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    store_d = i_memwrite;
                    ldop_d  = i_ldop;
                    addr_d  = i_addr;
                    be_d    = i_memwrite ? st_be : {BE_W{1'b1}};
                    wdata_d = i_memwrite ? st_wdata : '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (lsu_misaligned(i_memwrite, i_ldop, i_sop, i_addr[1:0])) begin
                        mis_d   = 1'b1;
                        state_d = LSU_RESP;
                    end else begin
                        mis_d   = 1'b0;
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_mem_gnt) begin
                    cnt_d = '0;
                    if (i_flush) begin
                        state_d = store_q ? LSU_IDLE : LSU_DRAIN;
                    end else begin
                        state_d = store_q ? LSU_RESP : LSU_WAIT;
                    end
                end else if (i_flush) begin
                    state_d = LSU_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_mem_rvalid) begin
                    if (i_flush) begin
                        state_d = LSU_IDLE;
                    end else begin
                        rdata_d = ld_rdata;
                        state_d = LSU_RESP;
                    end
                end else if (i_flush) begin
                    cnt_d   = '0;
                    state_d = LSU_DRAIN;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = LSU_RESP;
                end
            end
            LSU_DRAIN: begin
                // Swallow the response of a flushed load so it cannot leak into the next access.
                cnt_d = cnt_q + CNT_W'(1);
                if (i_mem_rvalid || timeout) begin
                    state_d = LSU_IDLE;
                end
            end
            LSU_RESP: begin
                rdata_d = '0;
                mis_d   = 1'b0;
                err_d   = 1'b0;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Outputs decode registered state; only o_stall sees the incoming start.
    assign o_stall      = start | (state_q == LSU_REQ) | (state_q == LSU_WAIT)
                                | (state_q == LSU_DRAIN);
    assign o_done       = (state_q == LSU_RESP);
    assign o_rdata      = rdata_q;
    assign o_misaligned = mis_q;
    assign o_bus_err    = err_q;
    assign o_mem_req    = (state_q == LSU_REQ);
    assign o_mem_we     = store_q;
    assign o_mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign o_mem_be     = be_q;
    assign o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import multicore_pkg::*;

    logic        i_clk, i_rst, i_valid, i_flush, i_memaccess, i_memwrite;
    t_ldop       i_ldop;
    t_sop        i_sop;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_done, o_misaligned, o_bus_err;
    logic [31:0] o_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_memaccess(i_memaccess), .i_memwrite(i_memwrite), .i_ldop(i_ldop), .i_sop(i_sop),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done),
        .o_rdata(o_rdata), .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        t_ldop       ld;
        t_sop        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          gd;
        int          rd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } resp_t;

    resp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every o_done pops the oldest expected response.
    always @(negedge i_clk) begin
        if (!i_rst && o_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("done_rdata", o_rdata, e.rdata);
                chk("done_misaligned", 32'(o_misaligned), 32'(e.mis));
                chk("done_bus_err", 32'(o_bus_err), 32'(e.err));
            end
        end
    end

    task automatic drive_start(input logic we, input t_ldop ld, input t_sop st,
                               input logic [31:0] addr, input logic [31:0] wdata);
        i_valid = 1'b1; i_memaccess = 1'b1; i_memwrite = we;
        i_ldop = ld; i_sop = st; i_addr = addr; i_wdata = wdata;
    endtask

    task automatic next_cycle();
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_memaccess = 1'b0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = $urandom; i_flush = 1'b0;
    endtask

    // Run one access with a responsive memory; checks bus payload, stall and latency.
    task automatic do_access(input vec_t v);
        int req_cnt, gnt_cyc, done_c, exp_done;
        req_cnt = 0; gnt_cyc = -1; done_c = -1;
        @(posedge i_clk); #1;
        drive_start(v.we, v.ld, v.st, v.addr, v.wdata);
        sb.push_back('{rdata: v.exp_rdata, mis: v.exp_mis, err: 1'b0});
        #1 chk("stall_at_start", 32'(o_stall), 32'd1);
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            if (o_mem_req) begin
                chk("mem_addr", o_mem_addr, {v.addr[31:2], 2'b00});
                chk("mem_be", 32'(o_mem_be), 32'(v.exp_be));
                chk("mem_we", 32'(o_mem_we), 32'(v.we));
                if (v.we) chk("mem_wdata", o_mem_wdata, v.exp_wdata);
                chk("stall_in_req", 32'(o_stall), 32'd1);
                if (req_cnt == v.gd) begin
                    i_mem_gnt = 1'b1;
                    gnt_cyc = c;
                end
                req_cnt++;
            end
            if (!v.we && gnt_cyc >= 0 && c == gnt_cyc + 1 + v.rd) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = v.rdata;
            end
            if (o_done) begin
                done_c = c;
                chk("stall_in_resp", 32'(o_stall), 32'd0);
                break;
            end
        end
        @(negedge i_clk);
        exp_done = v.exp_mis ? 1 : (v.we ? 2 + v.gd : 3 + v.gd + v.rd);
        chk("done_latency", 32'(done_c), 32'(exp_done));
        chk("req_cycles", 32'(req_cnt), v.exp_mis ? 32'd0 : 32'(v.gd + 1));
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_memaccess = 1'b0; i_memwrite = 1'b0;
        i_ldop = LDOP_LB; i_sop = SOP_SB; i_addr = '0; i_wdata = '0;
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

        //           we    ld        st      addr        wdata         rdata         be       exp_wdata     exp_rdata     mis  gd rd
        vecs.push_back('{1'b1, LDOP_LB,  SOP_SB, 32'h103, 32'h000000AB, 32'h0,        4'b1000, 32'hABABABAB, 32'h0,        1'b0, 0, 0});
        vecs.push_back('{1'b1, LDOP_LB,  SOP_SH, 32'h102, 32'h0000BEEF, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 1, 0});
        vecs.push_back('{1'b1, LDOP_LB,  SOP_SW, 32'h104, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 3, 0});
        vecs.push_back('{1'b1, LDOP_LB,  SOP_SB, 32'h100, 32'h1234565A, 32'h0,        4'b0001, 32'h5A5A5A5A, 32'h0,        1'b0, 0, 0});
        vecs.push_back('{1'b1, LDOP_LB,  SOP_SH, 32'h100, 32'hFFFF1234, 32'h0,        4'b0011, 32'h12341234, 32'h0,        1'b0, 0, 0});
        vecs.push_back('{1'b0, LDOP_LB,  SOP_SB, 32'h102, 32'h0,        32'h12803456, 4'b1111, 32'h0,        32'hFFFFFF80, 1'b0, 0, 0});
        vecs.push_back('{1'b0, LDOP_LBU, SOP_SB, 32'h102, 32'h0,        32'h12803456, 4'b1111, 32'h0,        32'h00000080, 1'b0, 0, 1});
        vecs.push_back('{1'b0, LDOP_LHU, SOP_SB, 32'h102, 32'h0,        32'h12803456, 4'b1111, 32'h0,        32'h00001280, 1'b0, 2, 0});
        vecs.push_back('{1'b0, LDOP_LH,  SOP_SB, 32'h100, 32'h0,        32'h1234F00D, 4'b1111, 32'h0,        32'hFFFFF00D, 1'b0, 0, 0});
        vecs.push_back('{1'b0, LDOP_LW,  SOP_SB, 32'h104, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0, 0, 2});
        vecs.push_back('{1'b0, LDOP_LB,  SOP_SB, 32'h101, 32'h0,        32'h12803456, 4'b1111, 32'h0,        32'h00000034, 1'b0, 0, 0});
        vecs.push_back('{1'b0, LDOP_LBU, SOP_SB, 32'h103, 32'h0,        32'hFF000000, 4'b1111, 32'h0,        32'h000000FF, 1'b0, 0, 0});
        vecs.push_back('{1'b0, LDOP_LW,  SOP_SB, 32'h102, 32'h0,        32'h0,        4'b1111, 32'h0,        32'h0,        1'b1, 0, 0});
        vecs.push_back('{1'b1, LDOP_LB,  SOP_SH, 32'h101, 32'h55,       32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 0, 0});
        vecs.push_back('{1'b0, LDOP_LHU, SOP_SB, 32'h103, 32'h0,        32'h0,        4'b1111, 32'h0,        32'h0,        1'b1, 0, 0});
        vecs.push_back('{1'b1, LDOP_LB,  SOP_SW, 32'h106, 32'h1,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 0, 0});

        // Reset state
        #12;
        chk("rst_mem_req", 32'(o_mem_req), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_mem_be", 32'(o_mem_be), 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        @(negedge i_clk); i_rst = 1'b0;

        foreach (vecs[i]) do_access(vecs[i]);

        // Timeout: gnt never arrives
        @(posedge i_clk); #1;
        drive_start(1'b1, LDOP_LB, SOP_SW, 32'h200, 32'h11223344);
        sb.push_back('{rdata: 32'h0, mis: 1'b0, err: 1'b1});
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            chk("to_req", 32'(o_mem_req), (c <= 8) ? 32'd1 : 32'd0);
            chk("to_done", 32'(o_done), (c == 9) ? 32'd1 : 32'd0);
        end

        // Load flushed in WAIT; orphaned rvalid two cycles later must not complete anything
        @(posedge i_clk); #1;
        drive_start(1'b0, LDOP_LW, SOP_SB, 32'h300, 32'h0);
        next_cycle(); chk("fl_req", 32'(o_mem_req), 32'd1); i_mem_gnt = 1'b1;
        next_cycle(); chk("fl_wait_stall", 32'(o_stall), 32'd1); i_flush = 1'b1;
        next_cycle(); chk("fl_drain_stall", 32'(o_stall), 32'd1);
        next_cycle(); i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
        next_cycle(); chk("fl_idle_stall", 32'(o_stall), 32'd0);
        do_access('{1'b1, LDOP_LB, SOP_SW, 32'h308, 32'h87654321, 32'h0, 4'b1111,
                    32'h87654321, 32'h0, 1'b0, 0, 0});

        // Flush in REQ without gnt drops the request
        @(posedge i_clk); #1;
        drive_start(1'b0, LDOP_LW, SOP_SB, 32'h400, 32'h0);
        next_cycle(); chk("frq_req", 32'(o_mem_req), 32'd1); i_flush = 1'b1;
        next_cycle(); chk("frq_req_drop", 32'(o_mem_req), 32'd0);
        chk("frq_stall", 32'(o_stall), 32'd0);

        // Flush with gnt on a store: committed, back to IDLE with no done
        @(posedge i_clk); #1;
        drive_start(1'b1, LDOP_LB, SOP_SW, 32'h404, 32'h5);
        next_cycle(); i_mem_gnt = 1'b1; i_flush = 1'b1;
        next_cycle(); chk("fgs_req", 32'(o_mem_req), 32'd0);
        chk("fgs_stall", 32'(o_stall), 32'd0);

        // Async reset while requesting
        @(posedge i_clk); #1;
        drive_start(1'b1, LDOP_LB, SOP_SW, 32'h500, 32'h9);
        next_cycle(); chk("ar_req_before", 32'(o_mem_req), 32'd1);
        #2 i_rst = 1'b1;
        #1 chk("ar_req_drop", 32'(o_mem_req), 32'd0);
        chk("ar_stall", 32'(o_stall), 32'd0);
        @(negedge i_clk); i_rst = 1'b0;
        do_access('{1'b0, LDOP_LH, SOP_SB, 32'h502, 32'h0, 32'h8001_0000, 4'b1111,
                    32'h0, 32'hFFFF8001, 1'b0, 0, 0});

        repeat (2) @(negedge i_clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
